// File: rtl/led_pattern_seq_if.sv
// rtl/led_pattern_seq_if.sv - button input and LED output bundle for led_pattern_seq
interface led_pattern_seq_if;
    logic       btn;
    logic [4:0] led;

    modport master (output btn, input led);
    modport slave  (input btn, output led);
endinterface

// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - five-LED animated pattern sequencer with debounced mode button and PWM dimming
module led_pattern_seq_core #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int STEP_HZ    = 8,
    parameter int DEB_CYCLES = 120_000,
    parameter int PWM_BITS   = 4,
    parameter int DUTY       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    led_pattern_seq_if.slave io
);
    localparam int STEP_DIV = CLK_HZ / STEP_HZ;
    localparam int PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [PWM_BITS:0] DUTY_CMP = (PWM_BITS + 1)'(DUTY);

    typedef enum logic [1:0] {
        MODE_ALL_ON = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic                btn_stable_q, btn_stable_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    mode_t               mode_q, mode_d;
    logic [4:0]          count_q, count_d;
    logic [2:0]          pos_q, pos_d;
    logic                dir_up_q, dir_up_d;
    logic                blink_q, blink_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [4:0]          led_q, led_d;

    logic                press;
    logic                tick;
    logic [4:0]          pat;
    logic                gate;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            btn_stable_q <= 1'b0;
            presc_q      <= '0;
            mode_q       <= MODE_ALL_ON;
            count_q      <= '0;
            pos_q        <= '0;
            dir_up_q     <= 1'b1;
            blink_q      <= 1'b1;
            pwm_cnt_q    <= '0;
            led_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            deb_cnt_q    <= deb_cnt_d;
            btn_stable_q <= btn_stable_d;
            presc_q      <= presc_d;
            mode_q       <= mode_d;
            count_q      <= count_d;
            pos_q        <= pos_d;
            dir_up_q     <= dir_up_d;
            blink_q      <= blink_d;
            pwm_cnt_q    <= pwm_cnt_d;
            led_q        <= led_d;
        end
    end

    // The stable level only follows the synchronised button after DEB_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        sync1_d      = io.btn;
        sync2_d      = sync1_q;
        deb_cnt_d    = deb_cnt_q;
        btn_stable_d = btn_stable_q;
        if (sync2_q == btn_stable_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            btn_stable_d = sync2_q;
            deb_cnt_d    = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
    end

    assign press = btn_stable_d & ~btn_stable_q;

    // A press restarts the step timer and the animation of the new mode, so a
    // tick landing on the same cycle is dropped.
    always_comb begin
        mode_d   = mode_q;
        count_d  = count_q;
        pos_d    = pos_q;
        dir_up_d = dir_up_q;
        blink_d  = blink_q;
        tick     = (presc_q == PRE_LAST);
        presc_d  = tick ? '0 : presc_q + PRE_W'(1);
        if (press) begin
            case (mode_q)
                MODE_ALL_ON: mode_d = MODE_COUNT;
                MODE_COUNT:  mode_d = MODE_BOUNCE;
                MODE_BOUNCE: mode_d = MODE_BLINK;
                default:     mode_d = MODE_ALL_ON;
            endcase
            presc_d  = '0;
            count_d  = '0;
            pos_d    = '0;
            dir_up_d = 1'b1;
            blink_d  = 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_COUNT: count_d = count_q + 5'd1;
                MODE_BOUNCE: begin
                    if (dir_up_q) begin
                        pos_d = pos_q + 3'd1;
                        if (pos_q == 3'd3) dir_up_d = 1'b0;
                    end else begin
                        pos_d = pos_q - 3'd1;
                        if (pos_q == 3'd1) dir_up_d = 1'b1;
                    end
                end
                MODE_BLINK: blink_d = ~blink_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (mode_q)
            MODE_COUNT:  pat = count_q;
            MODE_BOUNCE: pat = 5'b00001 << pos_q;
            MODE_BLINK:  pat = {5{blink_q}};
            default:     pat = 5'b11111;
        endcase
        // Extra compare bit lets DUTY == 2**PWM_BITS mean permanently on.
        gate      = ({1'b0, pwm_cnt_q} < DUTY_CMP);
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        led_d     = pat & {5{gate}};
    end

    assign io.led = led_q;
endmodule

module led_pattern_seq #(
    parameter int CLK_HZ     = 12_000_000,
    parameter int STEP_HZ    = 8,
    parameter int DEB_CYCLES = 120_000,
    parameter int PWM_BITS   = 4,
    parameter int DUTY       = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic LED0,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4
);
    led_pattern_seq_if io ();

    assign io.btn = btn;

    led_pattern_seq_core #(
        .CLK_HZ     (CLK_HZ),
        .STEP_HZ    (STEP_HZ),
        .DEB_CYCLES (DEB_CYCLES),
        .PWM_BITS   (PWM_BITS),
        .DUTY       (DUTY)
    ) u_core (
        .clk  (clk),
        .rstn (rstn),
        .io   (io)
    );

    assign LED0 = io.led[0];
    assign LED1 = io.led[1];
    assign LED2 = io.led[2];
    assign LED3 = io.led[3];
    assign LED4 = io.led[4];
endmodule
